// File: rtl/id_ex_operand_stage_pkg.sv
// id_ex_operand_stage_pkg: ALU control codes, aluop/funct constants and forwarding helper.
package id_ex_operand_stage_pkg;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_RTYPE = 2'b10;
  localparam logic [1:0] OP_OR    = 2'b11;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_SLT = 6'b101010;
  // EX/MEM beats MEM/WB; r0 is hardwired and never forwarded.
  function automatic logic [31:0] fwd_sel(
    input logic en, input logic [4:0] addr, input logic [31:0] raw,
    input logic xw, input logic [4:0] xrd, input logic [31:0] xres,
    input logic ww, input logic [4:0] wrd, input logic [31:0] wdata);
    return !en || addr == 5'd0 ? raw :
           xw && xrd == addr ? xres :
           ww && wrd == addr ? wdata : raw;
  endfunction
endpackage

// File: rtl/id_ex_operand_stage_alu_ctr_decode.sv
// alu_ctr_decode: maps aluop/funct to the 3-bit ALU control code and flags unknown R-type functs.
module alu_ctr_decode
  import id_ex_operand_stage_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctr,
  output logic       illegal
);
  always_comb begin
    alu_ctr = ALU_ADD;
    illegal = 1'b0;
    case (aluop)
      OP_SUB: alu_ctr = ALU_SUB;
      OP_OR:  alu_ctr = ALU_OR;
      OP_RTYPE:
        case (funct)
          F_ADD:   alu_ctr = ALU_ADD;
          F_SUB:   alu_ctr = ALU_SUB;
          F_AND:   alu_ctr = ALU_AND;
          F_OR:    alu_ctr = ALU_OR;
          F_XOR:   alu_ctr = ALU_XOR;
          F_NOR:   alu_ctr = ALU_NOR;
          F_SRL:   alu_ctr = ALU_SRL;
          F_SLT:   alu_ctr = ALU_SLT;
          default: illegal = 1'b1;
        endcase
      default: alu_ctr = ALU_ADD;
    endcase
  end
endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register with operand forwarding and ALU control decode.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        in_valid,
  input  logic        in_regwrite,
  input  logic        in_alusrc,
  input  logic [1:0]  in_aluop,
  input  logic [5:0]  in_funct,
  input  logic [4:0]  in_rs_addr,
  input  logic [4:0]  in_rt_addr,
  input  logic [4:0]  in_rd_addr,
  input  logic [31:0] in_rs_data,
  input  logic [31:0] in_rt_data,
  input  logic [31:0] in_imm,
  input  logic        exmem_regwrite,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_res,
  input  logic        memwb_regwrite,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_data,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [2:0]  ALU_Ctr,
  output logic        ex_valid,
  output logic        ex_regwrite,
  output logic        ex_illegal,
  output logic [4:0]  ex_rd,
  output logic [31:0] ex_store_data
);
  logic [31:0] rs_fwd, rt_fwd;
  logic [2:0]  ctr;
  logic        illegal;
  assign rs_fwd = fwd_sel(FWD_EN, in_rs_addr, in_rs_data, exmem_regwrite, exmem_rd, exmem_res,
                          memwb_regwrite, memwb_rd, memwb_data);
  assign rt_fwd = fwd_sel(FWD_EN, in_rt_addr, in_rt_data, exmem_regwrite, exmem_rd, exmem_res,
                          memwb_regwrite, memwb_rd, memwb_data);
  alu_ctr_decode u_dec (.aluop(in_aluop), .funct(in_funct), .alu_ctr(ctr), .illegal(illegal));
  // Reset, flush and an invalid slot all load the same bubble; flush beats stall.
  always_ff @(posedge clk) begin
    if (rst || flush || (!stall && !in_valid)) begin
      A             <= '0;
      B             <= '0;
      ex_store_data <= '0;
      ALU_Ctr       <= ALU_ADD;
      ex_rd         <= '0;
      ex_valid      <= 1'b0;
      ex_regwrite   <= 1'b0;
      ex_illegal    <= 1'b0;
    end else if (!stall) begin
      A             <= rs_fwd;
      B             <= in_alusrc ? in_imm : rt_fwd;
      ex_store_data <= rt_fwd;
      ALU_Ctr       <= ctr;
      ex_rd         <= in_rd_addr;
      ex_valid      <= 1'b1;
      ex_regwrite   <= in_regwrite && !illegal;
      ex_illegal    <= illegal;
    end
  end
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: directed and randomized checks against a behavioural model of the ID/EX stage.
module tb_id_ex_operand_stage;
  logic clk = 1'b0;
  logic rst, stall, flush, in_valid, in_regwrite, in_alusrc;
  logic [1:0] in_aluop;
  logic [5:0] in_funct;
  logic [4:0] in_rs_addr, in_rt_addr, in_rd_addr;
  logic [31:0] in_rs_data, in_rt_data, in_imm;
  logic exmem_regwrite, memwb_regwrite;
  logic [4:0] exmem_rd, memwb_rd;
  logic [31:0] exmem_res, memwb_data;
  logic [31:0] A, B, ex_store_data;
  logic [2:0] ALU_Ctr;
  logic ex_valid, ex_regwrite, ex_illegal;
  logic [4:0] ex_rd;
  int checks = 0, errors = 0;
  logic [31:0] e_a, e_b, e_sd;
  logic [2:0] e_ctr;
  logic [4:0] e_rd;
  logic e_v, e_rw, e_ill;
  logic [2:0] fmap [logic [5:0]];
  logic [2:0] opmap [4];
  logic [5:0] flist [8];

  id_ex_operand_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_regwrite(in_regwrite), .in_alusrc(in_alusrc), .in_aluop(in_aluop), .in_funct(in_funct),
    .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr), .in_rd_addr(in_rd_addr),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_res(exmem_res),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .A(A), .B(B), .ALU_Ctr(ALU_Ctr), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
    .ex_illegal(ex_illegal), .ex_rd(ex_rd), .ex_store_data(ex_store_data));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mfwd(input logic [4:0] a, input logic [31:0] raw);
    if (a == 5'd0) return raw;
    if (exmem_regwrite && exmem_rd == a) return exmem_res;
    if (memwb_regwrite && memwb_rd == a) return memwb_data;
    return raw;
  endfunction

  task automatic model();
    logic [31:0] rtv;
    logic ill;
    if (rst || flush || (!stall && !in_valid)) begin
      {e_a, e_b, e_sd, e_rd, e_v, e_rw, e_ill} = '0;
      e_ctr = 3'b010;
    end else if (!stall) begin
      rtv = mfwd(in_rt_addr, in_rt_data);
      ill = in_aluop == 2'b10 && !fmap.exists(in_funct);
      e_a = mfwd(in_rs_addr, in_rs_data);
      e_b = in_alusrc ? in_imm : rtv;
      e_sd = rtv;
      e_ctr = in_aluop != 2'b10 ? opmap[in_aluop] : ill ? 3'b010 : fmap[in_funct];
      e_rd = in_rd_addr;
      e_v = 1'b1;
      e_rw = in_regwrite && !ill;
      e_ill = ill;
    end
  endtask

  task automatic cycle();
    model();
    @(posedge clk);
    #1;
    chk("A", A, e_a);
    chk("B", B, e_b);
    chk("store", ex_store_data, e_sd);
    chk("rd", {27'd0, ex_rd}, {27'd0, e_rd});
    chk("flags", {29'd0, ex_valid, ex_regwrite, ex_illegal}, {29'd0, e_v, e_rw, e_ill});
    if (e_v) chk("ctr", {29'd0, ALU_Ctr}, {29'd0, e_ctr});
  endtask

  task automatic idle();
    {rst, stall, flush, in_valid, in_regwrite, in_alusrc, in_aluop, in_funct} = '0;
    {in_rs_addr, in_rt_addr, in_rd_addr, in_rs_data, in_rt_data, in_imm} = '0;
    {exmem_regwrite, exmem_rd, exmem_res, memwb_regwrite, memwb_rd, memwb_data} = '0;
  endtask

  initial begin
    fmap[6'b100000] = 3'b010; fmap[6'b100010] = 3'b110; fmap[6'b100100] = 3'b000;
    fmap[6'b100101] = 3'b001; fmap[6'b100110] = 3'b011; fmap[6'b100111] = 3'b100;
    fmap[6'b000010] = 3'b101; fmap[6'b101010] = 3'b111;
    opmap = '{3'b010, 3'b110, 3'b010, 3'b001};
    flist = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b000010, 6'b101010};
    idle();
    rst = 1'b1;
    cycle();
    chk("rst_ctr", {29'd0, ALU_Ctr}, 32'd2);
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    rst = 1'b0;
    in_valid = 1'b1; in_regwrite = 1'b1;
    in_rs_addr = 5'd3; in_rs_data = 32'd5;
    exmem_regwrite = 1'b1; exmem_rd = 5'd3; exmem_res = 32'h11;
    memwb_regwrite = 1'b1; memwb_rd = 5'd3; memwb_data = 32'h22;
    cycle();
    chk("fwd_exmem", A, 32'h11);
    exmem_regwrite = 1'b0;
    cycle();
    chk("fwd_memwb", A, 32'h22);
    in_rs_addr = 5'd0; in_rs_data = 32'd0; exmem_regwrite = 1'b1; exmem_rd = 5'd0;
    exmem_res = 32'hFFFF_FFFF; memwb_rd = 5'd0;
    cycle();
    chk("r0_nofwd", A, 32'd0);
    {exmem_regwrite, memwb_regwrite} = '0;
    in_aluop = 2'b10; in_funct = 6'b101010;
    cycle();
    chk("slt", {29'd0, ALU_Ctr}, 32'd7);
    in_funct = 6'b111111;
    cycle();
    chk("illegal_ctr", {29'd0, ALU_Ctr}, 32'd2);
    chk("illegal_flags", {30'd0, ex_illegal, ex_regwrite}, 32'b10);
    in_aluop = 2'b00; in_rs_addr = 5'd1; in_rs_data = 32'd7;
    cycle();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_rs_data = $urandom; in_rd_addr = 5'($urandom);
      cycle();
      chk("stall_hold", A, 32'd7);
    end
    flush = 1'b1;
    cycle();
    chk("stall_flush", {30'd0, ex_valid, ex_regwrite}, 32'd0);
    {stall, flush} = '0;
    in_alusrc = 1'b1; in_imm = 32'h10; in_rt_addr = 5'd2; in_rt_data = 32'h5;
    memwb_regwrite = 1'b1; memwb_rd = 5'd2; memwb_data = 32'h99;
    cycle();
    chk("imm_b", B, 32'h10);
    chk("store_fwd", ex_store_data, 32'h99);
    stall = 1'b1;
    cycle();
    rst = 1'b1;
    cycle();
    chk("rst_in_stall", {31'd0, ex_valid}, 32'd0);
    idle();
    for (int n = 0; n < 400; n++) begin
      rst = $urandom_range(0, 49) == 0;
      stall = $urandom_range(0, 5) == 0;
      flush = $urandom_range(0, 9) == 0;
      in_valid = $urandom_range(0, 7) != 0;
      in_regwrite = 1'($urandom); in_alusrc = 1'($urandom);
      in_aluop = 2'($urandom);
      in_funct = $urandom_range(0, 3) == 0 ? 6'($urandom) : flist[$urandom_range(0, 7)];
      in_rs_addr = 5'($urandom_range(0, 3)); in_rt_addr = 5'($urandom_range(0, 3));
      in_rd_addr = 5'($urandom);
      in_rs_data = $urandom; in_rt_data = $urandom; in_imm = $urandom;
      exmem_regwrite = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3)); exmem_res = $urandom;
      memwb_regwrite = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3)); memwb_data = $urandom;
      cycle();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
